bubsysrom_sram_busctrl: RTL and testbench
=========================================

# bubsysrom_sram_busctrl

Bus-side controller that sits directly upstream of the board's synchronous SRAM model and is the only block that drives its address, data and RD/WR strobes. It turns a level-held CPU chip-select access into single-cycle SRAM strobes, registers read data, and returns a DTACK-style acknowledge. It also contains a clear engine that sweeps every SRAM location to a fixed value on request, stalling the CPU while it runs.

## Interface
Parameters:
- AW, 10, SRAM address width; depth is 2**AW
- DW, 8, data width
- CLR_VAL, {DW{1'b0}}, value written by the clear engine

Ports:
- i_MCLK  in  1  master clock; all logic on rising edge
- i_RST  in  1  reset, synchronous, active-high
- i_CPU_CS  in  1  access request, held high until o_CPU_ACK is seen
- i_CPU_RW  in  1  1 = read, 0 = write; sampled with CS
- i_CPU_ADDR  in  AW  access address
- i_CPU_DIN  in  DW  write data
- o_CPU_DOUT  out  DW  registered read data; valid while o_CPU_ACK is high after a read
- o_CPU_ACK  out  1  access acknowledge
- i_CLR_REQ  in  1  single-cycle clear request
- o_CLR_BUSY  out  1  high while the clear sweep runs
- o_SRAM_ADDR  out  AW  to SRAM address
- o_SRAM_DIN  out  DW  to SRAM write data
- i_SRAM_DOUT  in  DW  from SRAM registered read data (1-cycle latency after RD)
- o_SRAM_RD  out  1  SRAM read strobe
- o_SRAM_WR  out  1  SRAM write strobe

## Operation
- States: IDLE, RD, RDLAT, WR, ACK, CLEAR.
- IDLE: if clear pending -> CLEAR (priority over CPU). Else if i_CPU_CS=1: latch ADDR, DIN, RW; RW=1 -> RD, else -> WR.
- RD: o_SRAM_RD=1, o_SRAM_ADDR=latched addr; -> RDLAT.
- RDLAT: capture i_SRAM_DOUT into o_CPU_DOUT; -> ACK.
- WR: o_SRAM_WR=1, o_SRAM_ADDR/o_SRAM_DIN = latched values; -> ACK.
- ACK: o_CPU_ACK=1; stay while i_CPU_CS=1; when CS=0 -> IDLE. A new access needs CS low for at least one sampled cycle.
- Clear pending flag: set by i_CLR_REQ in any state except CLEAR (requests during CLEAR are ignored, sweep does not restart); cleared on entry to CLEAR. A request during a CPU access is honoured only after that access returns to IDLE.
- CLEAR: o_CLR_BUSY=1, o_SRAM_WR=1, o_SRAM_DIN=CLR_VAL, o_SRAM_ADDR = counter from 0 to 2**AW-1, +1 per cycle; after the write at 2**AW-1 -> IDLE, counter returns to 0. No wrap or repeat.
- CS held high during CLEAR: no ack; access serviced from IDLE after sweep ends.
- o_SRAM_RD and o_SRAM_WR never high together; each high for exactly one cycle per CPU access.
- o_CPU_DOUT holds its last value outside reads; write data never appears on it.

## Timing
- All outputs registered. Reset value of every output: 0 (DOUT, ADDR, DIN all zero; ACK, BUSY, RD, WR low); state IDLE; pending flag cleared.
- Reset asserted mid-access or mid-clear: returns to IDLE next edge; no strobe in the cycle after reset; an interrupted clear is not resumed.
- Read: CS sampled high in IDLE at edge E0 -> o_SRAM_RD high cycle E0..E1 -> i_SRAM_DOUT valid E1..E2, captured at E2 -> o_CPU_ACK high from E3. Latency 3 cycles.
- Write: CS sampled at E0 -> o_SRAM_WR high E0..E1 -> ACK from E2. Latency 2 cycles.
- ACK drops the edge after CS is sampled low; earliest next CS sample is the following edge.
- Clear: i_CLR_REQ at edge R (state IDLE) -> pending set at R -> CLEAR entered at R+1, BUSY and WR high for exactly 2**AW cycles, then both low.
- CLR_REQ and CS sampled together in IDLE: CS access starts, clear follows after it completes.

## Test plan
- Reset with all inputs high -> all outputs 0 one cycle after reset; no strobe until reset released.
- Write 0xA5 to 0x123, then read 0x123 -> WR one cycle with ADDR=0x123 DIN=0xA5, ACK 2 cycles after CS; read ACK 3 cycles after CS with DOUT=0xA5.
- Hold CS for 10 cycles on a read -> exactly one RD pulse, ACK stays high until CS low, drops next cycle.
- Fill 0x000 and 0x3FF with 0xFF, pulse CLR_REQ -> BUSY high exactly 1024 cycles, addresses 0..0x3FF in order; subsequent reads of 0x000 and 0x3FF return 0x00.
- CLR_REQ mid-read, then second CLR_REQ during CLEAR -> read completes with correct data, single 1024-cycle sweep follows, no restart.
- CS high during CLEAR, and reset asserted at sweep address 0x200 -> no ACK during sweep; after reset outputs 0, no further sweep writes.

Source files
------------

// File: rtl/bubsysrom_sram_busctrl.sv
// -----------------------------------------------------------------------------
// bubsysrom_sram_busctrl
//
// The only block that drives the board SRAM's address, data and strobes. It
// turns a level-held CPU chip-select access into a single-cycle SRAM RD or WR
// strobe, captures the SRAM read data and returns a DTACK-style acknowledge.
// A clear engine sweeps every SRAM location to CLR_VAL on request and keeps
// the CPU stalled while it runs.
//
// Ports
//   i_MCLK        master clock, all logic on the rising edge
//   i_RST         synchronous active-high reset
//   i_CPU_CS      access request, held high until o_CPU_ACK is seen
//   i_CPU_RW      1 = read, 0 = write (sampled with CS)
//   i_CPU_ADDR    access address
//   i_CPU_DIN     write data
//   o_CPU_DOUT    registered read data, valid while o_CPU_ACK after a read
//   o_CPU_ACK     access acknowledge
//   i_CLR_REQ     single-cycle clear request
//   o_CLR_BUSY    high while the clear sweep runs
//   o_SRAM_ADDR   SRAM address
//   o_SRAM_DIN    SRAM write data
//   i_SRAM_DOUT   SRAM read data (one cycle after o_SRAM_RD)
//   o_SRAM_RD     SRAM read strobe
//   o_SRAM_WR     SRAM write strobe
// -----------------------------------------------------------------------------
module bubsysrom_sram_busctrl #(
  parameter int              AW      = 10,
  parameter int              DW      = 8,
  parameter logic [DW-1:0]   CLR_VAL = {DW{1'b0}}
) (
  input  logic          i_MCLK,
  input  logic          i_RST,
  input  logic          i_CPU_CS,
  input  logic          i_CPU_RW,
  input  logic [AW-1:0] i_CPU_ADDR,
  input  logic [DW-1:0] i_CPU_DIN,
  output logic [DW-1:0] o_CPU_DOUT,
  output logic          o_CPU_ACK,
  input  logic          i_CLR_REQ,
  output logic          o_CLR_BUSY,
  output logic [AW-1:0] o_SRAM_ADDR,
  output logic [DW-1:0] o_SRAM_DIN,
  input  logic [DW-1:0] i_SRAM_DOUT,
  output logic          o_SRAM_RD,
  output logic          o_SRAM_WR
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RDLAT,
    ST_WR,
    ST_ACK,
    ST_CLEAR
  } state_t;

  localparam logic [AW-1:0] CLR_LAST = {AW{1'b1}};

  state_t        state_reg,     state_next;
  logic          clr_pend_reg,  clr_pend_next;
  logic [AW-1:0] clr_cnt_reg,   clr_cnt_next;
  logic [AW-1:0] sram_addr_reg, sram_addr_next;
  logic [DW-1:0] sram_din_reg,  sram_din_next;
  logic          sram_rd_reg,   sram_rd_next;
  logic          sram_wr_reg,   sram_wr_next;
  logic [DW-1:0] cpu_dout_reg,  cpu_dout_next;
  logic          cpu_ack_reg,   cpu_ack_next;
  logic          clr_busy_reg,  clr_busy_next;

  // Every output is a register loaded from the next-state decode, so a strobe
  // is visible for exactly the cycle the FSM spends in the matching state.
  // The SRAM address/data registers also serve as the latched access fields.
  always_ff @(posedge i_MCLK) begin
    if (i_RST) begin
      state_reg     <= ST_IDLE;
      clr_pend_reg  <= 1'b0;
      clr_cnt_reg   <= '0;
      sram_addr_reg <= '0;
      sram_din_reg  <= '0;
      sram_rd_reg   <= 1'b0;
      sram_wr_reg   <= 1'b0;
      cpu_dout_reg  <= '0;
      cpu_ack_reg   <= 1'b0;
      clr_busy_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      clr_pend_reg  <= clr_pend_next;
      clr_cnt_reg   <= clr_cnt_next;
      sram_addr_reg <= sram_addr_next;
      sram_din_reg  <= sram_din_next;
      sram_rd_reg   <= sram_rd_next;
      sram_wr_reg   <= sram_wr_next;
      cpu_dout_reg  <= cpu_dout_next;
      cpu_ack_reg   <= cpu_ack_next;
      clr_busy_reg  <= clr_busy_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    // Requests arriving while the sweep runs are dropped, so a sweep never
    // restarts itself.
    clr_pend_next  = clr_pend_reg | (i_CLR_REQ && (state_reg != ST_CLEAR));
    clr_cnt_next   = clr_cnt_reg;
    sram_addr_next = sram_addr_reg;
    sram_din_next  = sram_din_reg;
    sram_rd_next   = 1'b0;
    sram_wr_next   = 1'b0;
    cpu_dout_next  = cpu_dout_reg;
    cpu_ack_next   = 1'b0;
    clr_busy_next  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // Only the registered pending flag is checked here: a request that
        // coincides with CS lets the CPU access go first.
        if (clr_pend_reg) begin
          state_next     = ST_CLEAR;
          clr_pend_next  = 1'b0;
          clr_cnt_next   = '0;
          sram_addr_next = '0;
          sram_din_next  = CLR_VAL;
          sram_wr_next   = 1'b1;
          clr_busy_next  = 1'b1;
        end else if (i_CPU_CS) begin
          sram_addr_next = i_CPU_ADDR;
          if (i_CPU_RW) begin
            state_next   = ST_RD;
            sram_rd_next = 1'b1;
          end else begin
            state_next    = ST_WR;
            sram_din_next = i_CPU_DIN;
            sram_wr_next  = 1'b1;
          end
        end
      end

      ST_RD: begin
        state_next = ST_RDLAT;
      end

      ST_RDLAT: begin
        // SRAM data for the strobe issued in ST_RD is valid this cycle.
        cpu_dout_next = i_SRAM_DOUT;
        state_next    = ST_ACK;
      end

      ST_WR: begin
        state_next = ST_ACK;
      end

      ST_ACK: begin
        // Ack is held as long as CS is; the first low sample both drops ack
        // and returns to IDLE, so back-to-back accesses need a CS gap.
        if (i_CPU_CS) begin
          cpu_ack_next = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
      end

      ST_CLEAR: begin
        if (clr_cnt_reg == CLR_LAST) begin
          state_next   = ST_IDLE;
          clr_cnt_next = '0;
        end else begin
          clr_cnt_next   = clr_cnt_reg + AW'(1);
          sram_addr_next = clr_cnt_reg + AW'(1);
          sram_wr_next   = 1'b1;
          clr_busy_next  = 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign o_CPU_DOUT  = cpu_dout_reg;
  assign o_CPU_ACK   = cpu_ack_reg;
  assign o_CLR_BUSY  = clr_busy_reg;
  assign o_SRAM_ADDR = sram_addr_reg;
  assign o_SRAM_DIN  = sram_din_reg;
  assign o_SRAM_RD   = sram_rd_reg;
  assign o_SRAM_WR   = sram_wr_reg;

endmodule

// File: tb/tb_bubsysrom_sram_busctrl.sv
// -----------------------------------------------------------------------------
// Testbench for bubsysrom_sram_busctrl: directed CPU accesses and clear sweeps
// against a small synchronous SRAM model, with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_bubsysrom_sram_busctrl;

  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          i_MCLK = 1'b0;
  logic          i_RST = 1'b1;
  logic          i_CPU_CS = 1'b0;
  logic          i_CPU_RW = 1'b0;
  logic [AW-1:0] i_CPU_ADDR = '0;
  logic [DW-1:0] i_CPU_DIN = '0;
  logic [DW-1:0] o_CPU_DOUT;
  logic          o_CPU_ACK;
  logic          i_CLR_REQ = 1'b0;
  logic          o_CLR_BUSY;
  logic [AW-1:0] o_SRAM_ADDR;
  logic [DW-1:0] o_SRAM_DIN;
  logic [DW-1:0] i_SRAM_DOUT = '0;
  logic          o_SRAM_RD;
  logic          o_SRAM_WR;

  always #5 i_MCLK = ~i_MCLK;

  bubsysrom_sram_busctrl #(.AW(AW), .DW(DW), .CLR_VAL(8'h00)) dut (
    .i_MCLK      (i_MCLK),
    .i_RST       (i_RST),
    .i_CPU_CS    (i_CPU_CS),
    .i_CPU_RW    (i_CPU_RW),
    .i_CPU_ADDR  (i_CPU_ADDR),
    .i_CPU_DIN   (i_CPU_DIN),
    .o_CPU_DOUT  (o_CPU_DOUT),
    .o_CPU_ACK   (o_CPU_ACK),
    .i_CLR_REQ   (i_CLR_REQ),
    .o_CLR_BUSY  (o_CLR_BUSY),
    .o_SRAM_ADDR (o_SRAM_ADDR),
    .o_SRAM_DIN  (o_SRAM_DIN),
    .i_SRAM_DOUT (i_SRAM_DOUT),
    .o_SRAM_RD   (o_SRAM_RD),
    .o_SRAM_WR   (o_SRAM_WR)
  );

  // Synchronous SRAM: write on WR, registered read one cycle after RD.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge i_MCLK) begin
    if (o_SRAM_WR) mem[o_SRAM_ADDR] <= o_SRAM_DIN;
    if (o_SRAM_RD) i_SRAM_DOUT <= mem[o_SRAM_ADDR];
  end

  // Strobe monitor, sampled shortly after each rising edge.
  int            rd_cnt = 0;
  int            wr_cnt = 0;
  int            both_cnt = 0;
  int            sweep_starts = 0;
  int            order_err = 0;
  int            ack_in_busy = 0;
  int            clr_seq = 0;
  logic          prev_busy = 1'b0;
  logic [AW-1:0] last_wr_addr = '0;
  logic [DW-1:0] last_wr_din = '0;

  always @(posedge i_MCLK) begin
    #2;
    if (o_SRAM_RD) rd_cnt++;
    if (o_SRAM_WR) begin
      wr_cnt++;
      last_wr_addr = o_SRAM_ADDR;
      last_wr_din  = o_SRAM_DIN;
    end
    if (o_SRAM_RD && o_SRAM_WR) both_cnt++;
    if (o_CLR_BUSY) begin
      if (!prev_busy) begin
        sweep_starts++;
        clr_seq = 0;
      end
      if (o_SRAM_ADDR != clr_seq[AW-1:0] || !o_SRAM_WR || o_SRAM_DIN != 8'h00)
        order_err++;
      clr_seq++;
      if (o_CPU_ACK) ack_in_busy++;
    end
    prev_busy = o_CLR_BUSY;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // One CPU access, called and returning at a falling edge. clr_edge selects
  // the cycle (0 = together with CS, k = after the k-th edge) at which a
  // one-cycle CLR_REQ is driven; -1 means none. hold = extra cycles CS stays
  // high after ack. lat = edges from the CS sample to ack visible (-1 = none).
  task automatic cpu_access(input logic rw, input logic [AW-1:0] addr,
                            input logic [DW-1:0] din, input int clr_edge,
                            input int hold, output logic [DW-1:0] dout,
                            output int lat, output int held, output logic dropped);
    bit got = 0;
    i_CPU_CS   = 1'b1;
    i_CPU_RW   = rw;
    i_CPU_ADDR = addr;
    i_CPU_DIN  = din;
    i_CLR_REQ  = (clr_edge == 0);
    lat  = -1;
    held = 0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge i_MCLK);
      i_CLR_REQ = (clr_edge == k);
      if (o_CPU_ACK) begin
        got = 1;
        lat = k - 1;
      end
    end
    dout = o_CPU_DOUT;
    for (int h = 0; h < hold; h++) begin
      @(negedge i_MCLK);
      i_CLR_REQ = 1'b0;
      if (o_CPU_ACK) held++;
    end
    i_CPU_CS  = 1'b0;
    i_CLR_REQ = 1'b0;
    @(negedge i_MCLK);
    dropped = o_CPU_ACK;
    $display("access rw=%0d addr=0x%03h din=0x%02h -> dout=0x%02h lat=%0d",
             rw, addr, din, dout, lat);
  endtask

  // Waits (from a falling edge) for BUSY to rise, then counts its high cycles.
  task automatic wait_sweep(output int wait_cyc, output int busy_cyc);
    wait_cyc = 0;
    busy_cyc = 0;
    while (!o_CLR_BUSY && wait_cyc < 20) begin
      @(negedge i_MCLK);
      wait_cyc++;
    end
    while (o_CLR_BUSY && busy_cyc < 3000) begin
      busy_cyc++;
      @(negedge i_MCLK);
    end
    $display("sweep wait=%0d busy=%0d", wait_cyc, busy_cyc);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"},  32'(o_CPU_ACK),   32'h0);
    chk({tag, "_busy"}, 32'(o_CLR_BUSY),  32'h0);
    chk({tag, "_rd"},   32'(o_SRAM_RD),   32'h0);
    chk({tag, "_wr"},   32'(o_SRAM_WR),   32'h0);
    chk({tag, "_addr"}, 32'(o_SRAM_ADDR), 32'h0);
    chk({tag, "_din"},  32'(o_SRAM_DIN),  32'h0);
    chk({tag, "_dout"}, 32'(o_CPU_DOUT),  32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    int            lat, held, w, b, w2, r0, wr0, s0, a0;
    logic          dropped;
    bit            hit;

    // ---- 1: reset with every input high ----
    i_RST = 1'b1; i_CPU_CS = 1'b1; i_CPU_RW = 1'b1; i_CPU_ADDR = '1;
    i_CPU_DIN = '1; i_CLR_REQ = 1'b1;
    repeat (3) @(negedge i_MCLK);
    chk_all_zero("rst");
    chk("rst_no_rd_pulses", 32'(rd_cnt), 32'h0);
    chk("rst_no_wr_pulses", 32'(wr_cnt), 32'h0);
    i_CPU_CS = 1'b0; i_CPU_RW = 1'b0; i_CPU_ADDR = '0; i_CPU_DIN = '0;
    i_CLR_REQ = 1'b0;
    i_RST = 1'b0;
    repeat (4) @(negedge i_MCLK);
    chk("post_rst_no_sweep", 32'(sweep_starts), 32'h0);

    // ---- 2: write 0xA5 @0x123 then read back ----
    r0 = rd_cnt; wr0 = wr_cnt;
    cpu_access(1'b0, 10'h123, 8'hA5, -1, 0, d, lat, held, dropped);
    chk("wr_latency", lat, 2);
    chk("wr_pulses", wr_cnt - wr0, 1);
    chk("wr_no_rd", rd_cnt - r0, 0);
    chk("wr_addr", 32'(last_wr_addr), 32'h123);
    chk("wr_din", 32'(last_wr_din), 32'hA5);
    chk("wr_dout_untouched", 32'(d), 32'h00);
    r0 = rd_cnt; wr0 = wr_cnt;
    cpu_access(1'b1, 10'h123, 8'h00, -1, 0, d, lat, held, dropped);
    chk("rd_latency", lat, 3);
    chk("rd_data", 32'(d), 32'hA5);
    chk("rd_pulses", rd_cnt - r0, 1);
    chk("rd_no_wr", wr_cnt - wr0, 0);
    chk("rd_ack_dropped", 32'(dropped), 32'h0);

    // ---- 3: read with CS held 10 cycles after ack ----
    cpu_access(1'b0, 10'h045, 8'h3C, -1, 0, d, lat, held, dropped);
    r0 = rd_cnt;
    cpu_access(1'b1, 10'h045, 8'h00, -1, 10, d, lat, held, dropped);
    chk("hold_rd_data", 32'(d), 32'h3C);
    chk("hold_ack_cycles", held, 10);
    chk("hold_ack_drop", 32'(dropped), 32'h0);
    chk("hold_single_rd", rd_cnt - r0, 1);
    chk("hold_dout_kept", 32'(o_CPU_DOUT), 32'h3C);

    // ---- 4: fill ends with 0xFF, clear sweep ----
    cpu_access(1'b0, 10'h000, 8'hFF, -1, 0, d, lat, held, dropped);
    cpu_access(1'b0, 10'h3FF, 8'hFF, -1, 0, d, lat, held, dropped);
    cpu_access(1'b1, 10'h3FF, 8'h00, -1, 0, d, lat, held, dropped);
    chk("fill_readback", 32'(d), 32'hFF);
    wr0 = wr_cnt; a0 = order_err;
    i_CLR_REQ = 1'b1;
    @(negedge i_MCLK);
    i_CLR_REQ = 1'b0;
    chk("clr_busy_not_yet", 32'(o_CLR_BUSY), 32'h0);
    wait_sweep(w, b);
    chk("clr_start_delay", w, 1);
    chk("clr_busy_cycles", b, 1024);
    chk("clr_wr_cycles", wr_cnt - wr0, 1024);
    chk("clr_addr_order", order_err - a0, 0);
    cpu_access(1'b1, 10'h000, 8'h00, -1, 0, d, lat, held, dropped);
    chk("clr_read_000", 32'(d), 32'h00);
    cpu_access(1'b1, 10'h3FF, 8'h00, -1, 0, d, lat, held, dropped);
    chk("clr_read_3ff", 32'(d), 32'h00);

    // ---- 5: CLR_REQ mid-read, second request and CS during the sweep ----
    cpu_access(1'b0, 10'h010, 8'h77, -1, 0, d, lat, held, dropped);
    s0 = sweep_starts; a0 = ack_in_busy;
    cpu_access(1'b1, 10'h010, 8'h00, 1, 0, d, lat, held, dropped);
    chk("midrd_latency", lat, 3);
    chk("midrd_data", 32'(d), 32'h77);
    w = 0;
    while (!o_CLR_BUSY && w < 20) begin
      @(negedge i_MCLK);
      w++;
    end
    chk("midrd_sweep_delay", w, 1);
    b = 0;
    while (o_CLR_BUSY && b < 3000) begin
      b++;
      i_CLR_REQ = (b == 100);
      if (b == 200) begin
        i_CPU_CS = 1'b1; i_CPU_RW = 1'b1; i_CPU_ADDR = 10'h010;
      end
      @(negedge i_MCLK);
    end
    i_CLR_REQ = 1'b0;
    $display("sweep busy=%0d with re-request and CS pending", b);
    chk("midrd_busy_cycles", b, 1024);
    w2 = 0;
    while (!o_CPU_ACK && w2 < 20) begin
      @(negedge i_MCLK);
      w2++;
    end
    chk("post_sweep_ack_delay", w2, 4);
    chk("post_sweep_rd_data", 32'(o_CPU_DOUT), 32'h00);
    i_CPU_CS = 1'b0;
    @(negedge i_MCLK);
    chk("post_sweep_ack_drop", 32'(o_CPU_ACK), 32'h0);
    repeat (30) @(negedge i_MCLK);
    chk("single_sweep", sweep_starts - s0, 1);
    chk("no_ack_in_sweep", ack_in_busy - a0, 0);

    // ---- 6: CLR_REQ with CS on a write, then reset mid-sweep ----
    s0 = sweep_starts;
    cpu_access(1'b0, 10'h3FF, 8'h5C, 0, 0, d, lat, held, dropped);
    chk("simul_wr_latency", lat, 2);
    wait_sweep(w, b);
    chk("simul_sweep_delay", w, 1);
    chk("simul_sweep_busy", b, 1024);
    cpu_access(1'b0, 10'h3FF, 8'h5C, -1, 0, d, lat, held, dropped);
    a0 = ack_in_busy;
    i_CLR_REQ = 1'b1;
    @(negedge i_MCLK);
    i_CLR_REQ = 1'b0;
    i_CPU_CS = 1'b1; i_CPU_RW = 1'b1; i_CPU_ADDR = 10'h123;
    hit = 0;
    for (int k = 0; k < 2000 && !hit; k++) begin
      @(negedge i_MCLK);
      if (o_CLR_BUSY && o_SRAM_ADDR == 10'h200) hit = 1;
    end
    chk("reached_0x200", 32'(hit), 32'h1);
    i_RST = 1'b1;
    @(negedge i_MCLK);
    chk_all_zero("midclr_rst");
    chk("midclr_no_ack", ack_in_busy - a0, 0);
    i_CPU_CS = 1'b0;
    @(negedge i_MCLK);
    i_RST = 1'b0;
    s0 = sweep_starts; wr0 = wr_cnt;
    repeat (30) @(negedge i_MCLK);
    chk("no_resume_sweep", sweep_starts - s0, 0);
    chk("no_resume_writes", wr_cnt - wr0, 0);
    cpu_access(1'b1, 10'h3FF, 8'h00, -1, 0, d, lat, held, dropped);
    chk("uncleared_3ff", 32'(d), 32'h5C);
    cpu_access(1'b1, 10'h000, 8'h00, -1, 0, d, lat, held, dropped);
    chk("cleared_000", 32'(d), 32'h00);
    chk("rd_wr_never_both", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
